// File: rtl/lsu_pkg.sv
// ============================================================================
//  Module   : lsu_pkg
//  Brief    : Shared encodings, FSM state type and lane helpers for the LSU.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package lsu_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WRITE  = 2'd2,
        RESP   = 2'd3
    } lsu_state_t;

    localparam logic [63:0] LANE_MASK_B = 64'h0000_0000_0000_00FF;
    localparam logic [63:0] LANE_MASK_H = 64'h0000_0000_0000_FFFF;
    localparam logic [63:0] LANE_MASK_W = 64'h0000_0000_FFFF_FFFF;
    localparam logic [63:0] LANE_MASK_D = 64'hFFFF_FFFF_FFFF_FFFF;

    function automatic logic [63:0] lane_mask(input logic [1:0] size);
        case (size)
            SZ_B:    return LANE_MASK_B;
            SZ_H:    return LANE_MASK_H;
            SZ_W:    return LANE_MASK_W;
            default: return LANE_MASK_D;
        endcase
    endfunction

    // Offset bits that must be zero for a naturally aligned access.
    function automatic logic [2:0] low_offset_mask(input logic [1:0] size);
        case (size)
            SZ_B:    return 3'b000;
            SZ_H:    return 3'b001;
            SZ_W:    return 3'b011;
            default: return 3'b111;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] offset);
        return |(offset & low_offset_mask(size));
    endfunction

    function automatic logic [2:0] align_down(input logic [1:0] size, input logic [2:0] offset);
        return offset & ~low_offset_mask(size);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_stage_lsu_align.sv
// ============================================================================
//  Module   : lsu_align
//  Brief    : Combinational load lane extract/extend and store lane merge.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [2:0]  i_offset,
    input  logic        i_signed,
    input  logic [63:0] i_rdata,
    input  logic [63:0] i_wdata,
    output logic [63:0] o_load_data,
    output logic [63:0] o_merge_data
);

    logic [5:0]  w_shamt;
    logic [63:0] w_lane;
    logic [63:0] w_mask;

    assign w_shamt = {i_offset, 3'b000};
    assign w_lane  = i_rdata >> w_shamt;
    assign w_mask  = lane_mask(i_size) << w_shamt;

    always_comb begin
        o_load_data = w_lane;
        case (i_size)
            SZ_B:    o_load_data = {{56{i_signed & w_lane[7]}},  w_lane[7:0]};
            SZ_H:    o_load_data = {{48{i_signed & w_lane[15]}}, w_lane[15:0]};
            SZ_W:    o_load_data = {{32{i_signed & w_lane[31]}}, w_lane[31:0]};
            default: o_load_data = w_lane;
        endcase
    end

    assign o_merge_data = (i_rdata & ~w_mask) | ((i_wdata << w_shamt) & w_mask);

endmodule

`default_nettype wire

// File: rtl/mem_stage_lsu.sv
// ============================================================================
//  Module   : mem_stage_lsu
//  Brief    : MEM-stage load/store unit: byte-addressed B/H/W/D requests to
//             doubleword memory/IO, sub-word store RMW, load extend.
//             Optional MISALIGN_CHECK_EN: reject misaligned requests with
//             rsp_err instead of aligning the offset down.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module mem_stage_lsu
    import lsu_pkg::*;
#(
    parameter int IDX_W  = 12,
    parameter int IO_BIT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_rdata,
    output logic        rsp_err,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    output logic        mem_we,
    input  logic [63:0] mem_rdata
);

    lsu_state_t  state_q, state_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        sgn_q, sgn_d;
    logic [2:0]  off_q, off_d;
    logic        io_q, io_d;
    logic [63:0] wdata_q, wdata_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [63:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;
    logic [63:0] mem_addr_q, mem_addr_d;
    logic [63:0] mem_wdata_q, mem_wdata_d;
    logic        mem_we_q, mem_we_d;

    logic        w_misaligned;
    logic        w_req_io;
    logic [63:0] w_load_data;
    logic [63:0] w_merge_data;
    logic        unused_addr_bits;

    // Upper address bits only matter through the index/IO fields below.
    assign unused_addr_bits = ^req_addr;
    assign w_req_io         = req_addr[IO_BIT];

`ifdef MISALIGN_CHECK_EN
    assign w_misaligned = is_misaligned(req_size, req_addr[2:0]);
`else
    assign w_misaligned = 1'b0;
`endif

    lsu_align u_align (
        .i_size       (size_q),
        .i_offset     (off_q),
        .i_signed     (sgn_q),
        .i_rdata      (mem_rdata),
        .i_wdata      (wdata_q),
        .o_load_data  (w_load_data),
        .o_merge_data (w_merge_data)
    );

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        size_d      = size_q;
        sgn_d       = sgn_q;
        off_d       = off_q;
        io_d        = io_q;
        wdata_d     = wdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = mem_we_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d        = req_we;
                    size_d      = req_size;
                    sgn_d       = req_signed;
                    off_d       = align_down(req_size, req_addr[2:0]);
                    io_d        = w_req_io;
                    wdata_d     = req_wdata;
                    mem_addr_d  = {{(64-IDX_W-1){1'b0}}, w_req_io, req_addr[IDX_W+2:3]};
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b0;
                    if (w_misaligned) begin
                        rsp_err_d   = 1'b1;
                        rsp_valid_d = 1'b1;
                        state_d     = RESP;
                    end else begin
                        state_d = ACCESS;
                        // Full-word and IO stores need no read, so strobe during ACCESS.
                        if (req_we && (w_req_io || req_size == SZ_D)) begin
                            mem_we_d    = 1'b1;
                            mem_wdata_d = w_req_io ? {56'b0, req_wdata[7:0]} : req_wdata;
                        end
                    end
                end
            end
            ACCESS: begin
                if (!we_q) begin
                    rsp_rdata_d = w_load_data;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else if (io_q || size_q == SZ_D) begin
                    mem_we_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    mem_wdata_d = w_merge_data;
                    mem_we_d    = 1'b1;
                    state_d     = WRITE;
                end
            end
            WRITE: begin
                mem_we_d    = 1'b0;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            size_q      <= SZ_B;
            sgn_q       <= 1'b0;
            off_q       <= 3'b000;
            io_q        <= 1'b0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            size_q      <= size_d;
            sgn_q       <= sgn_d;
            off_q       <= off_d;
            io_q        <= io_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
        end
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_we    = mem_we_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_stage_lsu.sv
// ============================================================================
//  Module   : tb_mem_stage_lsu
//  Brief    : Scoreboard bench for mem_stage_lsu with a byte-level reference
//             memory; honours MISALIGN_CHECK_EN when defined.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [63:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [63:0] rsp_rdata;
    logic        rsp_err;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic        mem_we;
    logic [63:0] mem_rdata;

    mem_stage_lsu #(.IDX_W(12), .IO_BIT(15)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errs   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Data memory / IO block seen by the DUT, plus a preload port for the bench.
    logic [63:0] mem [0:8191];
    logic        pl_en  = 1'b0;
    logic [12:0] pl_idx = '0;
    logic [63:0] pl_val = '0;

    always @(posedge clk) begin
        if (mem_we)     mem[mem_addr[12:0]] <= mem_wdata;
        else if (pl_en) mem[pl_idx]         <= pl_val;
    end
    assign mem_rdata = mem[mem_addr[12:0]];

    // Byte-granular reference image of the same storage.
    logic [7:0] ref_b [0:65535];

    typedef struct {
        logic [63:0] rdata;
        logic        err;
        string       tag;
    } exp_t;
    exp_t sb[$];

    int          cyc = 0;
    int          we_cnt = 0;
    int          we_cyc = 0;
    logic [63:0] we_addr = '0;
    int          viol = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_we) begin
                we_cnt++;
                we_cyc  = cyc;
                we_addr = mem_addr;
                if (req_ready || rsp_valid || mem_addr[63:13] != '0) viol++;
            end
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    check_eq("sb_empty", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check_eq({e.tag, ".rdata"}, rsp_rdata, e.rdata);
                    check_eq({e.tag, ".err"}, {63'b0, rsp_err}, {63'b0, e.err});
                end
            end
        end
    end

    task automatic preload(input logic [12:0] idx, input logic [63:0] val);
        for (int i = 0; i < 8; i++) ref_b[int'(idx) * 8 + i] = val[8*i +: 8];
        pl_idx = idx;
        pl_val = val;
        pl_en  = 1'b1;
        @(posedge clk);
        #1 pl_en = 1'b0;
    endtask

    function automatic logic [63:0] ref_word(input int idx);
        logic [63:0] v;
        for (int i = 0; i < 8; i++) v[8*i +: 8] = ref_b[idx * 8 + i];
        return v;
    endfunction

    // Reference behaviour: expected response, latency (edges after accept) and strobes.
    task automatic model(input logic we, input logic [1:0] sz, input logic sg,
                         input logic [63:0] addr, input logic [63:0] wd,
                         output logic [63:0] rd, output logic err,
                         output int lat, output int nwe, output int idx);
        int nb;
        int lane_raw;
        int lane;
        logic mis;
        nb       = 1 << sz;
        lane_raw = int'(addr[2:0]);
        idx      = int'({addr[15], addr[14:3]});
`ifdef MISALIGN_CHECK_EN
        mis = (lane_raw % nb) != 0;
`else
        mis = 1'b0;
`endif
        lane = lane_raw - (lane_raw % nb);
        rd = '0; err = 1'b0; lat = 1; nwe = 0;
        if (mis) begin
            err = 1'b1;
            lat = 0;
        end else if (!we) begin
            for (int i = 0; i < nb; i++) rd[8*i +: 8] = ref_b[idx*8 + lane + i];
            if (sg && nb < 8 && rd[8*nb - 1])
                for (int k = 8*nb; k < 64; k++) rd[k] = 1'b1;
        end else if (addr[15]) begin
            nwe = 1;
            for (int i = 0; i < 8; i++) ref_b[idx*8 + i] = (i == 0) ? wd[7:0] : 8'h00;
        end else begin
            nwe = 1;
            lat = (nb == 8) ? 1 : 2;
            for (int i = 0; i < nb; i++) ref_b[idx*8 + lane + i] = wd[8*i +: 8];
        end
    endtask

    task automatic do_req(input logic we, input logic [1:0] sz, input logic sg,
                          input logic [63:0] addr, input logic [63:0] wd,
                          input int hold, input string tag);
        exp_t e;
        int elat, nwe, idx, lat, a, w0;
        logic [63:0] d0;
        model(we, sz, sg, addr, wd, e.rdata, e.err, elat, nwe, idx);
        e.tag = tag;
        sb.push_back(e);
        req_we = we; req_size = sz; req_signed = sg; req_addr = addr; req_wdata = wd;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        a  = cyc;
        w0 = we_cnt;
        lat = 0;
        while (!rsp_valid && lat < 10) begin
            @(posedge clk);
            #1 lat++;
        end
        check_eq({tag, ".lat"}, 64'(lat), 64'(elat));
        if (hold > 0) begin
            d0 = rsp_rdata;
            repeat (hold) @(posedge clk);
            #1;
            check_eq({tag, ".hold_valid"}, {63'b0, rsp_valid}, 64'd1);
            check_eq({tag, ".hold_data"}, rsp_rdata, d0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        check_eq({tag, ".nwe"}, 64'(we_cnt - w0), 64'(nwe));
        if (nwe > 0) begin
            check_eq({tag, ".we_cycle"}, 64'(we_cyc - a), 64'(elat - 1));
            check_eq({tag, ".we_idx"}, we_addr, 64'(idx));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 65536; i++) ref_b[i] = 8'h00;
        for (int i = 0; i < 8192; i++) mem[i] = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        check_eq("rst.req_ready", {63'b0, req_ready}, 64'd1);
        check_eq("rst.rsp_valid", {63'b0, rsp_valid}, 64'd0);
        check_eq("rst.rsp_rdata", rsp_rdata, 64'd0);
        check_eq("rst.rsp_err",   {63'b0, rsp_err}, 64'd0);
        check_eq("rst.mem_addr",  mem_addr, 64'd0);
        check_eq("rst.mem_wdata", mem_wdata, 64'd0);
        check_eq("rst.mem_we",    {63'b0, mem_we}, 64'd0);

        do_req(1'b1, 2'b11, 1'b0, 64'h10, 64'h1122_3344_5566_7788, 0, "st_d");
        do_req(1'b0, 2'b11, 1'b0, 64'h10, 64'h0, 0, "ld_d");
        do_req(1'b1, 2'b00, 1'b0, 64'h13, 64'hFFFF_FFFF_FFFF_FFAB, 0, "st_b13");
        do_req(1'b0, 2'b11, 1'b0, 64'h10, 64'h0, 0, "ld_d_after_b");
        do_req(1'b0, 2'b11, 1'b0, 64'h0010_0010, 64'h0, 0, "ld_d_wrap");

        preload(13'd2, 64'h8001_0000_0000_0000);
        do_req(1'b0, 2'b01, 1'b1, 64'h16, 64'h0, 0, "ld_h_s");
        do_req(1'b0, 2'b01, 1'b0, 64'h16, 64'h0, 5, "ld_h_u_hold");
        do_req(1'b0, 2'b00, 1'b1, 64'h17, 64'h0, 0, "ld_b_s");
        do_req(1'b0, 2'b10, 1'b1, 64'h14, 64'h0, 0, "ld_w_s");
        do_req(1'b0, 2'b10, 1'b0, 64'h14, 64'h0, 0, "ld_w_u");

        do_req(1'b1, 2'b00, 1'b0, 64'h8000, 64'h0000_0000_0000_125A, 0, "io_st");
        do_req(1'b0, 2'b11, 1'b0, 64'h8000, 64'h0, 0, "io_ld_back");
        preload(13'h1001, 64'h0000_0000_0000_00C3);
        do_req(1'b0, 2'b00, 1'b0, 64'h8008, 64'h0, 0, "io_ld_c3");

        preload(13'd4, 64'h0123_4567_89AB_CDEF);
        do_req(1'b0, 2'b10, 1'b0, 64'h22, 64'h0, 0, "ld_w_mis");
        do_req(1'b1, 2'b01, 1'b0, 64'h25, 64'hBEEF, 0, "st_h_mis");
        do_req(1'b0, 2'b11, 1'b0, 64'h20, 64'h0, 0, "ld_d_after_mis");

        for (int i = 0; i < 8; i++)
            do_req(1'b1, 2'b00, 1'b0, 64'h40 + 64'(i), 64'(8'h10 + 8'(i * 8'h11)), 0, "st_lanes");
        do_req(1'b1, 2'b01, 1'b0, 64'h44, 64'hA5C3, 0, "st_h44");
        do_req(1'b1, 2'b10, 1'b0, 64'h48, 64'hCAFE_F00D, 0, "st_w48");
        do_req(1'b0, 2'b11, 1'b0, 64'h40, 64'h0, 0, "ld_lanes");
        do_req(1'b0, 2'b11, 1'b0, 64'h48, 64'h0, 0, "ld_w48");

        // Reset asserted while the RMW strobe is high: no write may land.
        preload(13'd6, 64'hDEAD_BEEF_CAFE_F00D);
        req_we = 1'b1; req_size = 2'b01; req_signed = 1'b0;
        req_addr = 64'h32; req_wdata = 64'h1234;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #1 check_eq("rstw.we_pre", {63'b0, mem_we}, 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("rstw.we_async", {63'b0, mem_we}, 64'd0);
        check_eq("rstw.rsp_valid", {63'b0, rsp_valid}, 64'd0);
        check_eq("rstw.req_ready", {63'b0, req_ready}, 64'd1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        check_eq("rstw.mem_kept", mem[6], ref_word(6));
        do_req(1'b0, 2'b11, 1'b0, 64'h30, 64'h0, 0, "rstw.ld");

        check_eq("we_outside_access", 64'(viol), 64'd0);
        check_eq("sb_drained", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

endmodule

`default_nettype wire
